lvds_line_ring_addr_gen: RTL
============================

Name: lvds_line_ring_addr_gen

Overview:
Parametrised line-buffer address generator between the LVDS pixel deserialiser and the dual-port line RAM. It turns each incoming pixel into a registered RAM write of address, data word and write enable. Base addresses advance per line through a ring of NUM_LINES slots. Occupancy is tracked against a downstream consumer that releases lines, so a full buffer drops whole lines and flags the drop.

Parameters:
PIX_W, 12, pixel data width; must be at most WORD_W
WORD_W, 16, RAM word width; pixel is zero-extended
ADDR_W, 10, RAM address width
MAX_PIXEL, 64, pixels per line slot; MAX_PIXEL*NUM_LINES must be at most 2^ADDR_W
NUM_LINES, 16, ring depth in lines
CNT_W, 5, Lines_avail width; must be at least clog2(NUM_LINES+1)

Ports:
SDR_CLK  in  1  pixel clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
Frame_start  in  1  one-cycle sync pulse; restarts the ring
Write_EN  in  1  line-valid level; high while pixels of one line arrive
Pixel_count  in  ADDR_W  pixel index within the current line
Pixel_data  in  PIX_W  pixel value
Line_release  in  1  one-cycle pulse; consumer has finished the oldest line
Address  out  ADDR_W  RAM write address
Data_Word  out  WORD_W  RAM write data, {zeros, pixel}
W_EN  out  1  RAM write enable
Line_done  out  1  one-cycle pulse; a line has been committed
Line_base  out  ADDR_W  base address of the most recently committed line
Lines_avail  out  CNT_W  committed lines not yet released
Overflow  out  1  sticky; a line was dropped because the ring was full
Pix_err  out  1  sticky; a pixel arrived with Pixel_count >= MAX_PIXEL

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; internal base, write pointer, previous-Write_EN register and line-active flags all 0.
- Pipeline: one-cycle latency. Inputs sampled at edge n appear on Address/Data_Word/W_EN after edge n.
- Address = base + Pixel_count, truncated to ADDR_W. Data_Word = Pixel_data zero-extended to WORD_W.
- W_EN = Write_EN AND line_accepted AND (Pixel_count < MAX_PIXEL). When the count check fails, set Pix_err and suppress the write.
- Edge detection is synchronous, using a registered copy of Write_EN. No logic runs on Write_EN edges as a clock.
- Line start (previous 0, current 1):
  - If Lines_avail == NUM_LINES and Line_release is low that cycle, the line is rejected: line_accepted = 0 for the whole line, Overflow is set, and no commit follows.
  - Otherwise line_accepted = 1 and the wrote_any flag is cleared.
- wrote_any is set by any accepted pixel that produced W_EN.
- Line end (previous 1, current 0) with line_accepted and wrote_any:
  - commit; on the next cycle Line_done = 1 and Line_base = current base;
  - base advances by MAX_PIXEL, wrapping to 0 when the result equals MAX_PIXEL*NUM_LINES;
  - Lines_avail increments.
- Line end of a rejected line, or one with no pixels written: no commit, base unchanged.
- Minimum gap: Write_EN must be low for at least 1 cycle between lines. A line starting on the cycle after commit uses the advanced base.
- Line_release:
  - decrements Lines_avail;
  - ignored when Lines_avail == 0;
  - commit and release in the same cycle leave Lines_avail unchanged.
- Frame_start has highest priority:
  - next cycle base = 0, Lines_avail = 0, Overflow = 0, Pix_err = 0, W_EN = 0, Line_done = 0;
  - an in-progress line is aborted without commit and stays unaccepted until Write_EN next rises.
- Lines_avail never exceeds NUM_LINES and never underflows.

Test Plan:
- Reset then idle -> Address=0, Data_Word=0, W_EN=0, Lines_avail=0, all flags 0.
- Line 0: Write_EN high for Pixel_count 0..63, Pixel_data=12'hA5C -> W_EN one cycle later, Address 0..63, Data_Word=16'h0A5C. After Write_EN falls: Line_done pulse, Line_base=0, Lines_avail=1.
- 16 lines with no release -> bases 0,64,...,960, Lines_avail=16. A 17th line gives W_EN=0 throughout, Overflow=1, no Line_done. Then one Line_release, then the 18th line writes addresses 0..63 (wrap).
- Pixel_count=64 inside an accepted line -> no W_EN for that pixel, Pix_err=1, remaining pixels still written.
- Line_release and a line commit in the same cycle at Lines_avail=3 -> Lines_avail stays 3. Line_release at Lines_avail=0 -> stays 0.
- Frame_start mid-line at pixel 20 of line 2 -> W_EN=0 next cycle, no Line_done, Lines_avail=0, flags cleared, next line writes from Address 0.

Source files
------------

// File: rtl/lvds_line_ring_addr_gen.sv
// Line-buffer write address generator: maps deserialised pixels into a ring of
// fixed-size line slots in the line RAM and tracks which lines are ready to consume.
module lvds_line_ring_addr_gen #(
   parameter int PIX_W     = 12,
   parameter int WORD_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int MAX_PIXEL = 64,
   parameter int NUM_LINES = 16,
   parameter int CNT_W     = 5
) (
   input  logic              SDR_CLK,
   input  logic              RST_N,
   input  logic              Frame_start,
   input  logic              Write_EN,
   input  logic [ADDR_W-1:0] Pixel_count,
   input  logic [PIX_W-1:0]  Pixel_data,
   input  logic              Line_release,
   output logic [ADDR_W-1:0] Address,
   output logic [WORD_W-1:0] Data_Word,
   output logic              W_EN,
   output logic              Line_done,
   output logic [ADDR_W-1:0] Line_base,
   output logic [CNT_W-1:0]  Lines_avail,
   output logic              Overflow,
   output logic              Pix_err
);

   // One extra bit so a full ring (MAX_PIXEL*NUM_LINES == 2^ADDR_W) is representable.
   localparam logic [ADDR_W:0]  MAX_EXT  = (ADDR_W+1)'(MAX_PIXEL);
   localparam logic [ADDR_W:0]  RING_EXT = (ADDR_W+1)'(MAX_PIXEL * NUM_LINES);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LINES);

   logic [ADDR_W-1:0] base_reg;
   logic              we_prev_reg;
   logic              line_accepted_reg;
   logic              wrote_any_reg;

   logic              line_start;
   logic              line_end;
   logic              ring_full;
   logic              accept_now;
   logic              in_range;
   logic              wr_now;
   logic              commit;
   logic              rel_ok;
   logic [ADDR_W:0]   base_sum;
   logic [ADDR_W-1:0] base_adv;

   always_comb begin
      line_start = Write_EN & ~we_prev_reg;
      line_end   = ~Write_EN & we_prev_reg;
      ring_full  = (Lines_avail == FULL_CNT);
      // A release in the same cycle frees the slot the new line needs.
      accept_now = line_start ? ~(ring_full & ~Line_release) : line_accepted_reg;
      in_range   = ({1'b0, Pixel_count} < MAX_EXT);
      wr_now     = Write_EN & accept_now & in_range;
      commit     = line_end & line_accepted_reg & wrote_any_reg;
      rel_ok     = Line_release & (Lines_avail != '0);
      base_sum   = {1'b0, base_reg} + MAX_EXT;
      base_adv   = (base_sum == RING_EXT) ? '0 : base_sum[ADDR_W-1:0];
   end

   always_ff @(posedge SDR_CLK or negedge RST_N) begin
      if (!RST_N) begin
         base_reg          <= '0;
         we_prev_reg       <= 1'b0;
         line_accepted_reg <= 1'b0;
         wrote_any_reg     <= 1'b0;
         Address           <= '0;
         Data_Word         <= '0;
         W_EN              <= 1'b0;
         Line_done         <= 1'b0;
         Line_base         <= '0;
         Lines_avail       <= '0;
         Overflow          <= 1'b0;
         Pix_err           <= 1'b0;
      end else begin
         we_prev_reg <= Write_EN;
         Address     <= base_reg + Pixel_count;
         Data_Word   <= WORD_W'(Pixel_data);
         if (Frame_start) begin
            // Abort any line in flight; it stays unaccepted until Write_EN rises again.
            base_reg          <= '0;
            line_accepted_reg <= 1'b0;
            wrote_any_reg     <= 1'b0;
            W_EN              <= 1'b0;
            Line_done         <= 1'b0;
            Lines_avail       <= '0;
            Overflow          <= 1'b0;
            Pix_err           <= 1'b0;
         end else begin
            W_EN              <= wr_now;
            Line_done         <= commit;
            line_accepted_reg <= accept_now;
            if (line_start & ~accept_now)
               Overflow <= 1'b1;
            if (Write_EN & ~in_range)
               Pix_err <= 1'b1;
            if (line_start)
               wrote_any_reg <= wr_now;
            else if (wr_now)
               wrote_any_reg <= 1'b1;
            if (commit) begin
               Line_base <= base_reg;
               base_reg  <= base_adv;
            end
            if (commit & ~rel_ok & ~ring_full)
               Lines_avail <= Lines_avail + CNT_W'(1);
            else if (~commit & rel_ok)
               Lines_avail <= Lines_avail - CNT_W'(1);
         end
      end
   end

endmodule
